// File: rtl/seven_seg_scan_driver.sv
// Segment-side driver for a 4-digit multiplexed seven-segment display.
// Generates the refresh tick for the external anode rotator, decodes the nibble
// selected by the fed-back anode vector and blanks the segments around every
// anode change. Host writes are held in a pending register and committed only
// when the rotator wraps from the last digit back to digit 0.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iLoad,
  input  logic [15:0] ivData,
  input  logic [3:0]  ivDp,
  input  logic        iLzb,
  input  logic [3:0]  ivAnode,
  output logic        oCE,
  output logic        oBusy,
  output logic [6:0]  ovSegment,
  output logic        oDp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLANK_LOAD    = BW'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF       = 7'h7F;

  logic [PW-1:0] prescaleReg;
  logic          ceReg;
  logic [15:0]   pendingReg;
  logic [3:0]    pendingDpReg;
  logic          busyReg;
  logic [15:0]   displayReg;
  logic [3:0]    dpDispReg;
  logic [BW-1:0] blankReg;
  logic [6:0]    segReg;
  logic          dpReg;

  logic          commitNow;
  logic [1:0]    digitSel;
  logic          digitValid;
  logic [3:0]    nibble [4];
  logic [3:0]    lzBlank;
  logic [6:0]    hexSeg;
  logic [6:0]    segNext;
  logic          dpNext;

  // Commit happens on the tick that moves the rotator off the last digit,
  // so the new value is visible from the first digit of the next frame.
  assign commitNow = ceReg && (ivAnode == 4'b0111) && busyReg;

  // Per-digit nibble view of the display and leading-zero flags: a digit is a
  // leading zero when it and every higher nibble are zero; digit 0 never is.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gDigit
      assign nibble[gi] = displayReg[4*gi +: 4];
      if (gi == 0) begin : gFirst
        assign lzBlank[gi] = 1'b0;
      end else begin : gUpper
        assign lzBlank[gi] = (displayReg[15:4*gi] == '0);
      end
    end
  endgenerate

  // Map the active-low one-hot anode vector to a digit index; anything else is invalid.
  always_comb begin
    digitSel   = 2'd0;
    digitValid = 1'b1;
    case (ivAnode)
      4'b1110: digitSel = 2'd0;
      4'b1101: digitSel = 2'd1;
      4'b1011: digitSel = 2'd2;
      4'b0111: digitSel = 2'd3;
      default: digitValid = 1'b0;
    endcase
  end

  // Hex to active-low segment pattern, bit0 = a ... bit6 = g.
  always_comb begin
    hexSeg = SEG_OFF;
    case (nibble[digitSel])
      4'h0: hexSeg = 7'b1000000;
      4'h1: hexSeg = 7'b1111001;
      4'h2: hexSeg = 7'b0100100;
      4'h3: hexSeg = 7'b0110000;
      4'h4: hexSeg = 7'b0011001;
      4'h5: hexSeg = 7'b0010010;
      4'h6: hexSeg = 7'b0000010;
      4'h7: hexSeg = 7'b1111000;
      4'h8: hexSeg = 7'b0000000;
      4'h9: hexSeg = 7'b0010000;
      4'hA: hexSeg = 7'b0001000;
      4'hB: hexSeg = 7'b0000011;
      4'hC: hexSeg = 7'b1000110;
      4'hD: hexSeg = 7'b0100001;
      4'hE: hexSeg = 7'b0000110;
      4'hF: hexSeg = 7'b0001110;
      default: hexSeg = SEG_OFF;
    endcase
  end

  // Output pattern for the selected digit; a blanked leading zero keeps its DP.
  always_comb begin
    segNext = SEG_OFF;
    dpNext  = 1'b1;
    if (digitValid) begin
      dpNext = ~dpDispReg[digitSel];
      if (!(iLzb && lzBlank[digitSel])) begin
        segNext = hexSeg;
      end
    end
  end

  // Refresh prescaler: wraps every REFRESH_DIV cycles and emits a one-cycle tick.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      prescaleReg <= '0;
      ceReg       <= 1'b0;
    end else begin
      prescaleReg <= (prescaleReg == PRESCALE_LAST) ? '0 : prescaleReg + PW'(1);
      ceReg       <= (prescaleReg == PRESCALE_LAST);
    end
  end

  // Host write buffer and frame-aligned commit; a load on the commit edge
  // refills pending after the old value has moved to the display.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      pendingReg   <= '0;
      pendingDpReg <= '0;
      busyReg      <= 1'b0;
      displayReg   <= '0;
      dpDispReg    <= '0;
    end else begin
      if (commitNow) begin
        displayReg <= pendingReg;
        dpDispReg  <= pendingDpReg;
      end
      if (iLoad) begin
        pendingReg   <= ivData;
        pendingDpReg <= ivDp;
        busyReg      <= 1'b1;
      end else if (commitNow) begin
        busyReg <= 1'b0;
      end
    end
  end

  // Anti-ghosting blank window after every tick, then registered decode.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      blankReg <= BLANK_LOAD;
      segReg   <= SEG_OFF;
      dpReg    <= 1'b1;
    end else if (ceReg) begin
      blankReg <= BLANK_LOAD;
      segReg   <= SEG_OFF;
      dpReg    <= 1'b1;
    end else if (blankReg != '0) begin
      blankReg <= blankReg - BW'(1);
      segReg   <= SEG_OFF;
      dpReg    <= 1'b1;
    end else begin
      segReg <= segNext;
      dpReg  <= dpNext;
    end
  end

  assign oCE       = ceReg;
  assign oBusy     = busyReg;
  assign ovSegment = segReg;
  assign oDp       = dpReg;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: directed scenarios plus a randomized run,
// all checked every cycle against a behavioural model that counts cycles since
// reset release and derives ticks, blank windows, commits and decode from that.
module tb_seven_seg_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic        iClk = 1'b0;
  logic        iReset = 1'b1;
  logic        iLoad = 1'b0;
  logic [15:0] ivData = '0;
  logic [3:0]  ivDp = '0;
  logic        iLzb = 1'b0;
  logic [3:0]  ivAnode = 4'b1110;
  logic        oCE;
  logic        oBusy;
  logic [6:0]  ovSegment;
  logic        oDp;

  int nAsserts = 0;
  int nFails   = 0;

  seven_seg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .iClk(iClk), .iReset(iReset), .iLoad(iLoad), .ivData(ivData), .ivDp(ivDp),
    .iLzb(iLzb), .ivAnode(ivAnode), .oCE(oCE), .oBusy(oBusy),
    .ovSegment(ovSegment), .oDp(oDp)
  );

  always #5 iClk = ~iClk;

  // Environment: rotator position and optional illegal-anode override.
  logic [3:0] rotAnode = 4'b1110;
  bit         forceIllegal = 1'b0;
  logic [3:0] illegalPattern = 4'b1100;
  logic [3:0] illegalSet [6] = '{4'b0000, 4'b1111, 4'b1100, 4'b0011, 4'b1010, 4'b0110};

  // Reference model state.
  int         n = 0;
  bit         mBusy = 0;
  logic [15:0] mPend = '0, mDisp = '0;
  logic [3:0]  mPdp = '0, mDdp = '0;
  logic [6:0]  mSeg = 7'h7F;
  bit          mDp = 1;
  bit          mDecoded = 0;
  logic [3:0]  mLastAnode = 4'b1110;

  logic [6:0] hexTab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nAsserts++;
    assert (got === exp)
    else begin
      nFails++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic logic [3:0] anodeFor(input int k);
    logic [3:0] oneHot;
    oneHot = 4'b0001 << k;
    return ~oneHot;
  endfunction

  function automatic void decode(input logic [3:0] an, input logic [15:0] d,
                                 input logic [3:0] dp, input bit lzb,
                                 output logic [6:0] s, output bit p);
    int k;
    logic [15:0] upper;
    k = -1;
    for (int i = 0; i < 4; i++) if (an == anodeFor(i)) k = i;
    s = 7'h7F;
    p = 1'b1;
    if (k >= 0) begin
      upper = d >> (4 * k);
      p = ~dp[k];
      if (!(lzb && k > 0 && upper == 16'h0)) s = hexTab[upper[3:0]];
    end
  endfunction

  // One clock: predict from current inputs, clock, then compare all outputs.
  task automatic step();
    bit ceNow, commit, blanked;
    logic [15:0] oldDisp;
    logic [3:0]  oldDdp;
    logic [6:0]  s;
    bit p;
    ivAnode    = forceIllegal ? illegalPattern : rotAnode;
    mLastAnode = ivAnode;
    oldDisp = mDisp;
    oldDdp  = mDdp;
    ceNow   = 0;
    if (iReset) begin
      n = 0; mBusy = 0; mPend = '0; mPdp = '0; mDisp = '0; mDdp = '0;
      mSeg = 7'h7F; mDp = 1; mDecoded = 0;
    end else begin
      ceNow  = (n > 0) && (n % DIV == 0);
      commit = ceNow && (ivAnode == 4'b0111) && mBusy;
      if (commit) begin mDisp = mPend; mDdp = mPdp; mBusy = 0; end
      if (iLoad) begin mPend = ivData; mPdp = ivDp; mBusy = 1; end
      n++;
      blanked = (n <= BLANK) || (n > DIV && ((n - 1) % DIV) <= BLANK);
      if (blanked) begin
        mSeg = 7'h7F; mDp = 1;
      end else begin
        decode(ivAnode, oldDisp, oldDdp, iLzb, s, p);
        mSeg = s; mDp = p;
      end
      mDecoded = !blanked;
    end
    @(posedge iClk);
    #1;
    if (iReset) rotAnode = 4'b1110;
    else if (ceNow) rotAnode = {rotAnode[2:0], rotAnode[3]};
    chk("oCE", oCE, 16'((n > 0) && (n % DIV == 0)));
    chk("oBusy", oBusy, 16'(mBusy));
    chk("ovSegment", ovSegment, 16'(mSeg));
    chk("oDp", oDp, 16'(mDp));
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    ivData = d; ivDp = dp; iLoad = 1'b1;
    step();
    iLoad = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int i;
    for (i = 0; i < 200 && mBusy; i++) step();
    chk({tag, "_idle"}, oBusy, 16'd0);
  endtask

  // Run until digit k is decoded on the display, then check it against constants.
  task automatic waitDigit(input string tag, input int k, input logic [6:0] seg, input bit dp);
    bit found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (mLastAnode == anodeFor(k) && mDecoded) found = 1;
    end
    chk({tag, "_found"}, 16'(found), 16'd1);
    chk({tag, "_seg"}, ovSegment, 16'(seg));
    chk({tag, "_dp"}, oDp, 16'(dp));
  endtask

  initial begin
    #1;
    // Reset held for three cycles, then free-running prescaler/blanking.
    iReset = 1'b1;
    repeat (3) step();
    chk("reset_seg", ovSegment, 16'h7F);
    chk("reset_dp", oDp, 16'd1);
    chk("reset_busy", oBusy, 16'd0);
    iReset = 1'b0;
    repeat (30) step();

    // Load 1A8F with DP on digit 1, commit at frame wrap, read one frame.
    load(16'h1A8F, 4'b0010);
    chk("load_busy", oBusy, 16'd1);
    waitIdle("load1A8F");
    waitDigit("d0_F", 0, 7'b0001110, 1'b1);
    waitDigit("d1_8", 1, 7'b0000000, 1'b0);
    waitDigit("d2_A", 2, 7'b0001000, 1'b1);
    waitDigit("d3_1", 3, 7'b1111001, 1'b1);

    // Leading-zero blanking; digit 2 DP stays lit while its segments are blank.
    iLzb = 1'b1;
    load(16'h0005, 4'b0100);
    waitIdle("lzb");
    waitDigit("lzb_d0", 0, 7'b0010010, 1'b1);
    waitDigit("lzb_d1", 1, 7'h7F, 1'b1);
    waitDigit("lzb_d2", 2, 7'h7F, 1'b0);
    waitDigit("lzb_d3", 3, 7'h7F, 1'b1);
    iLzb = 1'b0;
    waitDigit("nolzb_d1", 1, 7'b1000000, 1'b1);
    waitDigit("nolzb_d3", 3, 7'b1000000, 1'b1);

    // Double load then a load colliding with the commit edge.
    waitDigit("pre_dbl", 0, 7'b0010010, 1'b1);
    load(16'h1111, 4'b0000);
    load(16'h2222, 4'b0000);
    for (int i = 0; i < 200; i++) begin
      if (n > 0 && n % DIV == 0 && rotAnode == 4'b0111 && mBusy) break;
      step();
    end
    load(16'h3333, 4'b0000);
    chk("collide_busy", oBusy, 16'd1);
    waitDigit("collide_d0_2", 0, 7'b0100100, 1'b1);
    waitIdle("collide");
    waitDigit("collide_d0_3", 0, 7'b0110000, 1'b1);

    // Illegal anode pattern forced for a while.
    forceIllegal = 1'b1;
    illegalPattern = 4'b1100;
    repeat (2 * DIV) step();
    chk("illegal_seg", ovSegment, 16'h7F);
    chk("illegal_dp", oDp, 16'd1);
    forceIllegal = 1'b0;

    // Reset mid-operation with a pending value that must be discarded.
    load(16'hABCD, 4'b1111);
    repeat (3) step();
    iReset = 1'b1;
    step();
    chk("midrst_busy", oBusy, 16'd0);
    chk("midrst_seg", ovSegment, 16'h7F);
    iReset = 1'b0;
    waitDigit("midrst_d0", 0, 7'b1000000, 1'b1);
    waitDigit("midrst_d3", 3, 7'b1000000, 1'b1);
    chk("midrst_idle", oBusy, 16'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      iLoad  = ($urandom_range(0, 15) == 0);
      ivData = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ivData = 16'($urandom_range(0, 255));
      ivDp   = 4'($urandom);
      if ($urandom_range(0, 49) == 0) iLzb = ~iLzb;
      if ($urandom_range(0, 39) == 0) begin
        forceIllegal = ~forceIllegal;
        illegalPattern = illegalSet[$urandom_range(0, 5)];
      end
      iReset = ($urandom_range(0, 299) == 0);
      step();
    end
    iLoad = 1'b0;
    iReset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Drives the segment/cathode side of the 4-digit multiplexed seven-segment display.
- Generates the refresh clock-enable pulse that steps the downstream anode rotator.
- Decodes the nibble for the currently active anode into active-low segments.
- Blanks segments around each anode change to prevent ghosting.
- Buffers host writes and commits them only at frame boundaries, so a frame never shows mixed old/new digits.

Parameters:
REFRESH_DIV, 50000, clock cycles between oCE pulses; legal range ≥ 4.
BLANK_CYCLES, 4, extra blanking cycles after each oCE; legal range 2 ≤ BLANK_CYCLES < REFRESH_DIV-1.

Ports:
iClk  in  1  clock (already decided).
iReset  in  1  synchronous, active-high reset (already decided).
iLoad  in  1  one-cycle write strobe for ivData/ivDp.
ivData  in  16  hex value; digit0 = [3:0] … digit3 = [15:12].
ivDp  in  4  decimal-point enable per digit, 1 = lit.
iLzb  in  1  leading-zero blanking enable, level-sensitive.
ivAnode  in  4  active-low anode vector fed back from the rotator.
oCE  out  1  one-cycle refresh tick to the rotator's iCE.
oBusy  out  1  high while a loaded value awaits commit.
ovSegment  out  7  active-low segments, bit0 = a … bit6 = g.
oDp  out  1  active-low decimal point.

Behaviour:
Reset values:
- Prescaler count = 0, oCE = 0.
- Pending reg = 0, display reg = 0, DP regs = 0, oBusy = 0.
- Blank counter = BLANK_CYCLES.
- ovSegment = 7'h7F, oDp = 1.

Prescaler:
- Counts 0..REFRESH_DIV-1 and wraps.
- oCE is registered and high for exactly one cycle when the count wraps.
- First oCE occurs REFRESH_DIV cycles after reset release.

Digit select (decoded from ivAnode):
- 4'b1110 → digit 0; 4'b1101 → digit 1; 4'b1011 → digit 2; 4'b0111 → digit 3.
- Any other pattern (zero-hot or multi-hot) → segments 7'h7F, oDp = 1.

Load handshake:
- iLoad = 1: capture ivData/ivDp into the pending reg; oBusy ← 1 on the next edge.
- iLoad while busy overwrites pending (last write wins); no error is raised.

Commit:
- Triggered on an edge where oCE = 1, ivAnode = 4'b0111 (last digit; rotator wraps to digit 0) and oBusy = 1.
- display ← pending; oBusy ← 0.
- If iLoad is also high on that edge: the old pending value commits, the new value enters pending, and oBusy stays 1.

Blanking:
- On an edge with oCE = 1: blank counter ← BLANK_CYCLES, ovSegment ← 7'h7F, oDp ← 1.
- On each following edge with counter ≠ 0: counter decrements and outputs stay blanked.
- First decoded output for the new digit appears BLANK_CYCLES+1 cycles after the oCE cycle.
- This covers the rotator's one-cycle anode update lag.

Decode (registered, 1-cycle latency from ivAnode/display):
- Standard hex codes: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, A = 7'b0001000, F = 7'b0001110.
- oDp = ~dp[digit].

Leading-zero blanking (iLzb = 1):
- Digit k ≥ 1 shows 7'h7F when its nibble and all higher nibbles are zero.
- Digit 0 is never blanked.
- The DP of a blanked digit still follows ivDp.

Reset asserted mid-operation:
- Returns all state to reset values on that edge.
- Pending data is discarded.

Test Plan:
1. Reset and prescaler (REFRESH_DIV = 8, BLANK_CYCLES = 2), hold reset 3 cycles then release → oCE pulses at cycles 8, 16, 24, each exactly one cycle wide; ovSegment = 7'h7F until the first decoded output.
2. Load 16'h1A8F with ivDp = 4'b0010, rotator attached → oBusy = 1 until the oCE where ivAnode = 0111; across the next frame the digits read F, 8 (oDp = 0), A, 1 = 7'b0001110, 7'b0000000, 7'b0001000, 7'b1111001.
3. Blanking, observed after any oCE → ovSegment = 7'h7F on the 3 edges after the oCE (cycles +1..+3); the decoded digit appears at cycle +4.
4. Leading-zero blanking: load 16'h0005 with iLzb = 1 → digits 3, 2, 1 show 7'h7F and digit 0 shows 7'b0010010; with iLzb = 0 → digits 3, 2, 1 show 7'b1000000.
5. Double load and collision: load 16'h1111, then 16'h2222 before commit → only 2222 is displayed. Load 16'h3333 on the same edge as a commit → 2222 is shown for one frame, then 3333, with oBusy high in between.
6. Illegal anode 4'b1100 forced, and reset asserted mid-frame → segments 7'h7F and oDp = 1 for the illegal anode; reset clears display to 0 and oBusy to 0 with pending discarded.
